// File: rtl/temp_readout_pkg.sv
// Shared types, glyph constants and helpers for the temperature readout.
package temp_readout_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_BCD, S_LOAD} state_e;

  typedef enum logic [1:0] {
    CELSIUS    = 2'b00,
    FAHRENHEIT = 2'b01,
    KELVIN     = 2'b10,
    INVALID    = 2'b11
  } unit_e;

  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_K     = 7'h09;

  localparam logic [8:0] F_OFFSET = 9'd32;
  localparam logic [8:0] K_OFFSET = 9'd273;

  // Segment pattern g..a, active-low, for one decimal digit.
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = 7'h40;
      4'd1:    digit_glyph = 7'h79;
      4'd2:    digit_glyph = 7'h24;
      4'd3:    digit_glyph = 7'h30;
      4'd4:    digit_glyph = 7'h19;
      4'd5:    digit_glyph = 7'h12;
      4'd6:    digit_glyph = 7'h02;
      4'd7:    digit_glyph = 7'h78;
      4'd8:    digit_glyph = 7'h00;
      4'd9:    digit_glyph = 7'h10;
      default: digit_glyph = GLYPH_BLANK;
    endcase
  endfunction

  // Double-dabble correction applied to the three BCD nibbles before a shift.
  function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      else                     r[i*4 +: 4] = r[i*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/temp_readout_seg7_scan.sv
// Time-multiplexed 4-digit common-anode scanner; reusable by any display user.
module seg7_scan
  import temp_readout_pkg::*;
#(
  parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
  input  logic            clk_i,
  input  logic            clr_ni,
  input  logic            load_i,
  input  logic [3:0][6:0] glyph_i,
  output logic [6:0]      seg_o,
  output logic [3:0]      an_o
);

  logic [15:0] cnt_q;
  logic [1:0]  idx_q;
  logic [1:0]  idx_d;
  logic        wrap_s;
  logic [6:0]  seg_q;
  logic [3:0]  an_q;

  assign wrap_s = (cnt_q == (REFRESH_DIV - 16'd1));
  assign idx_d  = wrap_s ? (idx_q - 2'd1) : idx_q;

  // Refresh counter, digit index and registered segment/anode drive.
  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      cnt_q <= 16'd0;
      idx_q <= 2'd0;
      seg_q <= GLYPH_BLANK;
      an_q  <= 4'hF;
    end else begin
      cnt_q <= wrap_s ? 16'd0 : (cnt_q + 16'd1);
      idx_q <= idx_d;
      // glyph_i carries the post-load values, so a load shows up on this same edge
      if (wrap_s || load_i) seg_q <= glyph_i[idx_d];
      if (wrap_s)           an_q  <= ~(4'b0001 << idx_d);
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule

// File: rtl/temp_readout.sv
// Converts the stored temperature word to C/F/K, BCD-encodes it and scans it out.
// Build option: TEMP_READOUT_LZB_EN enables leading-zero blanking of hundreds/tens.
module temp_readout
  import temp_readout_pkg::*;
#(
  parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] d_in,
  input  logic [1:0] t_in,
  input  logic       upd,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [3:0] an
);

  state_e          state_q;
  unit_e           unit_q;
  logic [3:0]      c_q;
  logic [3:0]      step_q;
  logic [20:0]     dd_q;
  logic [6:0]      ug_q;
  logic            inv_q;
  logic            pending_q;
  logic            busy_q;
  logic            done_q;
  logic [3:0][6:0] disp_q;
  logic [3:0][6:0] disp_d;

  logic [8:0]  v_s;
  logic [6:0]  ug_s;
  logic        inv_s;
  logic [20:0] adj_s;
  logic [20:0] dd_d;
  logic [3:0]  hun_s, ten_s, one_s;

  // Unit conversion of the captured Celsius value.
  always_comb begin
    v_s   = 9'd0;
    ug_s  = GLYPH_DASH;
    inv_s = 1'b0;
    case (unit_q)
      CELSIUS:    begin v_s = {5'd0, c_q};                                ug_s = GLYPH_C; end
      FAHRENHEIT: begin v_s = F_OFFSET + (({5'd0, c_q} * 9'd9) / 9'd5);   ug_s = GLYPH_F; end
      KELVIN:     begin v_s = {5'd0, c_q} + K_OFFSET;                     ug_s = GLYPH_K; end
      default:    begin inv_s = 1'b1; end
    endcase
  end

  assign adj_s = {bcd_adjust(dd_q[20:9]), dd_q[8:0]};
  assign dd_d  = {adj_s[19:0], 1'b0};
  assign hun_s = dd_q[20:17];
  assign ten_s = dd_q[16:13];
  assign one_s = dd_q[12:9];

  // Next display contents; only the LOAD state changes them.
  always_comb begin
    disp_d = disp_q;
    if (state_q == S_LOAD) begin
      if (inv_q) begin
        disp_d = {4{GLYPH_DASH}};
      end else begin
`ifdef TEMP_READOUT_LZB_EN
        disp_d[3] = (hun_s == 4'd0) ? GLYPH_BLANK : digit_glyph(hun_s);
        disp_d[2] = ((hun_s == 4'd0) && (ten_s == 4'd0)) ? GLYPH_BLANK : digit_glyph(ten_s);
`else
        disp_d[3] = digit_glyph(hun_s);
        disp_d[2] = digit_glyph(ten_s);
`endif
        disp_d[1] = digit_glyph(one_s);
        disp_d[0] = ug_q;
      end
    end else begin
      disp_d = disp_q;
    end
  end

  // Conversion sequencer with one-deep pending request.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      unit_q    <= CELSIUS;
      c_q       <= 4'd0;
      step_q    <= 4'd0;
      dd_q      <= 21'd0;
      ug_q      <= GLYPH_BLANK;
      inv_q     <= 1'b0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      disp_q    <= {4{GLYPH_BLANK}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (upd) begin
            c_q     <= d_in;
            unit_q  <= unit_e'(t_in);
            busy_q  <= 1'b1;
            state_q <= S_CONV;
          end
        end
        S_CONV: begin
          if (upd) pending_q <= 1'b1;
          dd_q    <= {12'd0, v_s};
          inv_q   <= inv_s;
          ug_q    <= ug_s;
          step_q  <= 4'd0;
          state_q <= S_BCD;
        end
        S_BCD: begin
          if (upd) pending_q <= 1'b1;
          dd_q   <= dd_d;
          step_q <= step_q + 4'd1;
          if (step_q == 4'd8) state_q <= S_LOAD;
        end
        S_LOAD: begin
          disp_q <= disp_d;
          done_q <= 1'b1;
          // an upd arriving right now is serviced like an earlier pending one
          if (pending_q || upd) begin
            pending_q <= 1'b0;
            c_q       <= d_in;
            unit_q    <= unit_e'(t_in);
            busy_q    <= 1'b1;
            state_q   <= S_CONV;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  seg7_scan #(.REFRESH_DIV(REFRESH_DIV)) u_scan (
    .clk_i   (clk),
    .clr_ni  (clr_n),
    .load_i  (state_q == S_LOAD),
    .glyph_i (disp_d),
    .seg_o   (seg),
    .an_o    (an)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_temp_readout.sv
// Directed-vector bench for temp_readout with a short scan period.
module tb_temp_readout;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic [3:0] d_in = 4'd0;
  logic [1:0] t_in = 2'd0;
  logic       upd = 1'b0;
  logic       busy, done;
  logic [6:0] seg;
  logic [3:0] an;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] DA = 7'h3F;
  localparam logic [6:0] GC = 7'h46;
  localparam logic [6:0] GF = 7'h0E;
  localparam logic [6:0] GK = 7'h09;
  localparam logic [6:0] DIG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  temp_readout #(.REFRESH_DIV(16'd2)) dut (
    .clk(clk), .clr_n(clr_n), .d_in(d_in), .t_in(t_in), .upd(upd),
    .busy(busy), .done(done), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_upd(input logic [3:0] d, input logic [1:0] t);
    @(negedge clk);
    d_in = d; t_in = t; upd = 1'b1;
    @(posedge clk); #1;
    upd = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp);
    int k;
    k = 0;
    while (!done && k < exp + 8) begin
      @(posedge clk); #1;
      k++;
    end
    check_val({tag, "_lat"}, k, exp);
  endtask

  task automatic expect_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
    logic [3:0][6:0] cap;
    logic [3:0]      seen;
    seen = 4'h0;
    cap  = {4{BL}};
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      case (an)
        4'h7: begin cap[3] = seg; seen[3] = 1'b1; end
        4'hB: begin cap[2] = seg; seen[2] = 1'b1; end
        4'hD: begin cap[1] = seg; seen[1] = 1'b1; end
        4'hE: begin cap[0] = seg; seen[0] = 1'b1; end
        default: ;
      endcase
    end
    check_val({tag, "_seen"}, seen, 4'hF);
    check_val({tag, "_d3"}, cap[3], e3);
    check_val({tag, "_d2"}, cap[2], e2);
    check_val({tag, "_d1"}, cap[1], e1);
    check_val({tag, "_d0"}, cap[0], e0);
  endtask

  task automatic expect_num(input string tag, input int h, input int t, input int o,
                            input logic [6:0] ug);
    logic [6:0] e3, e2;
    e3 = DIG[h];
    e2 = DIG[t];
`ifdef TEMP_READOUT_LZB_EN
    if (h == 0) e3 = BL;
    if (h == 0 && t == 0) e2 = BL;
`endif
    expect_display(tag, e3, e2, DIG[o], ug);
  endtask

  task automatic convert(input string tag, input logic [3:0] d, input logic [1:0] t);
    pulse_upd(d, t);
    check_val({tag, "_busy1"}, busy, 1'b1);
    wait_done(tag, 11);
    check_val({tag, "_busy0"}, busy, 1'b0);
  endtask

  initial begin
    int cnt;
    // reset state and free-running scan
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_seg", seg, 7'h7F);
    check_val("rst_an", an, 4'hF);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    @(negedge clk); clr_n = 1'b1;
    @(posedge clk); #1;
    check_val("scan_pre", an, 4'hF);
    @(posedge clk); #1;
    check_val("scan_an3", an, 4'h7);
    repeat (2) @(posedge clk); #1;
    check_val("scan_an2", an, 4'hB);
    repeat (2) @(posedge clk); #1;
    check_val("scan_an1", an, 4'hD);
    repeat (2) @(posedge clk); #1;
    check_val("scan_an0", an, 4'hE);
    check_val("scan_seg", seg, 7'h7F);
    repeat (2) @(posedge clk); #1;
    check_val("scan_wrap", an, 4'h7);
    check_val("scan_busy", busy, 1'b0);

    convert("f15", 4'd15, 2'b01);  expect_num("f15", 0, 5, 9, GF);
    convert("k7",  4'd7,  2'b10);  expect_num("k7",  2, 8, 0, GK);
    convert("c0",  4'd0,  2'b00);  expect_num("c0",  0, 0, 0, GC);
    convert("k15", 4'd15, 2'b10);  expect_num("k15", 2, 8, 8, GK);
    convert("f0",  4'd0,  2'b01);  expect_num("f0",  0, 3, 2, GF);
    convert("inv", 4'd6,  2'b11);  expect_display("inv", DA, DA, DA, DA);

    // pending request absorbed mid-conversion, latest data wins
    pulse_upd(4'd3, 2'b00);
    repeat (3) @(posedge clk); #1;
    check_val("pend_busy_a", busy, 1'b1);
    pulse_upd(4'd9, 2'b01);
    wait_done("pend1", 7);
    check_val("pend1_busy", busy, 1'b1);
    expect_num("pend1", 0, 0, 3, GC);
    check_val("pend_busy_b", busy, 1'b1);
    wait_done("pend2", 4);
    check_val("pend2_busy", busy, 1'b0);
    expect_num("pend2", 0, 4, 8, GF);

    // reset in the middle of a conversion
    pulse_upd(4'd11, 2'b00);
    repeat (4) @(posedge clk);
    @(negedge clk); clr_n = 1'b0;
    #1;
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_seg", seg, 7'h7F);
    check_val("abort_an", an, 4'hF);
    check_val("abort_done", done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); clr_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    check_val("abort_nodone", cnt, 0);
    convert("c12", 4'd12, 2'b00);  expect_num("c12", 0, 1, 2, GC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
